// File: rtl/ex_stage_if.sv
// ex_stage_if: ID->EX operand bus, EX->MEM result bus and the valid/allowin handshake of the EX stage.
interface ex_stage_if #(parameter int DATA_W = 32);
    logic              ex_valid_i;
    logic              mem_allowin_i;
    logic              flush_i;
    logic              ex_allowin_o;
    logic              ex_to_mem_valid_o;
    logic              div_busy_o;
    logic [3:0]        op_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [DATA_W-1:0] pc_i;
    logic [4:0]        dest_i;
    logic [DATA_W-1:0] result_o;
    logic [4:0]        dest_o;
    logic [DATA_W-1:0] pc_o;
    modport master (
        output ex_valid_i, mem_allowin_i, flush_i, op_i, src1_i, src2_i, pc_i, dest_i,
        input  ex_allowin_o, ex_to_mem_valid_o, div_busy_o, result_o, dest_o, pc_o
    );
    modport slave (
        input  ex_valid_i, mem_allowin_i, flush_i, op_i, src1_i, src2_i, pc_i, dest_i,
        output ex_allowin_o, ex_to_mem_valid_o, div_busy_o, result_o, dest_o, pc_o
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: EX pipeline stage with single-cycle ALU and an iterative restoring divider that stalls via allowin.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input logic        clk,
    input logic        rst_n,
    ex_stage_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic              sgn1_q, sgn1_d, sgn2_q, sgn2_d;
    logic              is_div, is_signed, is_mod, ready_go, ge;
    logic [DATA_W:0]   rem_sh, rem_diff;
    logic [DATA_W-1:0] src1_abs, src2_abs, quo_fix, rem_fix, alu;
    logic [4:0]        shamt;
    assign is_div    = bus.op_i inside {4'd11, 4'd12, 4'd13, 4'd14};
    assign is_signed = bus.op_i == 4'd11 || bus.op_i == 4'd12;
    assign is_mod    = bus.op_i == 4'd12 || bus.op_i == 4'd14;
    assign ready_go  = !is_div || state_q == DONE;
    assign bus.ex_allowin_o      = !bus.ex_valid_i || (ready_go && bus.mem_allowin_i);
    assign bus.ex_to_mem_valid_o = bus.ex_valid_i && ready_go && !bus.flush_i;
    assign bus.div_busy_o        = state_q != IDLE;
    assign src1_abs = is_signed && bus.src1_i[DATA_W-1] ? -bus.src1_i : bus.src1_i;
    assign src2_abs = is_signed && bus.src2_i[DATA_W-1] ? -bus.src2_i : bus.src2_i;
    assign rem_sh   = {rem_q, quo_q[DATA_W-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign ge       = rem_sh >= {1'b0, dvs_q};
    // divide-by-zero keeps the all-ones quotient unsigned-looking regardless of operand signs
    assign quo_fix  = (sgn1_q ^ sgn2_q) && dvs_q != '0 ? -quo_q : quo_q;
    assign rem_fix  = sgn1_q ? -rem_q : rem_q;
    assign shamt    = bus.src2_i[4:0];
    always_comb begin
        alu = '0;
        case (bus.op_i)
            4'd0:    alu = bus.src1_i + bus.src2_i;
            4'd1:    alu = bus.src1_i - bus.src2_i;
            4'd2:    alu = bus.src1_i & bus.src2_i;
            4'd3:    alu = bus.src1_i | bus.src2_i;
            4'd4:    alu = bus.src1_i ^ bus.src2_i;
            4'd5:    alu = {{(DATA_W-1){1'b0}}, $signed(bus.src1_i) < $signed(bus.src2_i)};
            4'd6:    alu = {{(DATA_W-1){1'b0}}, bus.src1_i < bus.src2_i};
            4'd7:    alu = bus.src1_i << shamt;
            4'd8:    alu = bus.src1_i >> shamt;
            4'd9:    alu = DATA_W'($signed(bus.src1_i) >>> shamt);
            4'd10:   alu = bus.src2_i;
            default: alu = is_div ? (is_mod ? rem_fix : quo_fix) : '0;
        endcase
    end
    assign bus.result_o = bus.ex_valid_i ? alu : '0;
    assign bus.dest_o   = bus.ex_valid_i ? bus.dest_i : 5'd0;
    assign bus.pc_o     = bus.pc_i;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        sgn1_d  = sgn1_q;
        sgn2_d  = sgn2_q;
        if (bus.flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            quo_d   = '0;
            rem_d   = '0;
            dvs_d   = '0;
            sgn1_d  = 1'b0;
            sgn2_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.ex_valid_i && is_div) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    quo_d   = src1_abs;
                    rem_d   = '0;
                    dvs_d   = src2_abs;
                    sgn1_d  = is_signed && bus.src1_i[DATA_W-1];
                    sgn2_d  = is_signed && bus.src2_i[DATA_W-1];
                end
                BUSY: begin
                    quo_d   = {quo_q[DATA_W-2:0], ge};
                    rem_d   = ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
                    cnt_d   = cnt_q + 1'b1;
                    state_d = cnt_q == CNT_W'(DATA_W-1) ? DONE : BUSY;
                end
                DONE:    state_d = bus.mem_allowin_i ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            sgn1_q  <= 1'b0;
            sgn2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            sgn1_q  <= sgn1_d;
            sgn2_q  <= sgn2_d;
        end
    end
endmodule
